dds_amplitude_apply: RTL and testbench

- Consumer end of the DDS amplitude-select path.
- Takes the one-hot divisor code (1/2/4/8/16) produced by the key-driven amplitude selector and applies it to the DDS sample stream.
- Scaling is an arithmetic right shift about the DAC midscale.
- Code changes are held pending and committed only at a midscale crossing, or after a timeout, so the DAC output never steps mid-cycle.

---
 rtl/dds_amplitude_apply.sv | 169 ++++++++++++++++
 tb/tb_dds_amplitude_apply.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_amplitude_apply.sv
// ---------------------------------------------------------------------------
// dds_amplitude_apply
//
// Consumer end of the DDS amplitude-select path. A one-hot divisor code
// (1/2/4/8/16) from the key-driven selector scales the offset-binary DDS
// sample stream by an arithmetic right shift about DAC midscale. A new code
// is held pending and committed only on a midscale crossing, or after
// TIMEOUT_SAMPLES valid samples without one. This keeps the DAC output from
// stepping in the middle of a waveform cycle.
//
// Optional build macro:
//   DDS_AMP_ROUND_EN  defined   -> round-half-up shift, (s + 2^(k-1)) >>> k
//                     undefined -> truncating shift (round toward -inf)
//
// Ports:
//   clk               system clock
//   rst               synchronous, active-high reset
//   amplitude[4:0]    divisor code from selector; non-one-hot values ignored
//   sample_in         DDS sample, offset binary, DATA_W bits
//   sample_valid_in   sample_in qualifier
//   sample_out        scaled sample, offset binary (holds when not valid)
//   sample_valid_out  sample_out qualifier, sample_valid_in delayed 2 clocks
//   amp_active[4:0]   divisor code currently applied
//   amp_update        one-cycle pulse when a new code is committed
// ---------------------------------------------------------------------------
module dds_amplitude_apply #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned TIMEOUT_SAMPLES = 1024,
    parameter int unsigned CNT_W           = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        amplitude,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid_in,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid_out,
    output logic [4:0]        amp_active,
    output logic              amp_update
);

    localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [4:0]        CODE_DIV1 = 5'd1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_SAMPLES - 1);

    // Shift amount for a one-hot divisor code.
    function automatic logic [2:0] code_to_shift(input logic [4:0] code);
        logic [2:0] k;
        case (code)
            5'd2:    k = 3'd1;
            5'd4:    k = 3'd2;
            5'd8:    k = 3'd3;
            5'd16:   k = 3'd4;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

    // -----------------------------------------------------------------------
    // Code sampling and commit control
    // -----------------------------------------------------------------------
    logic [4:0]       pending;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] timeout_cnt_next;
    logic             prev_sign;

    logic             code_legal;
    logic             pending_change;
    logic             sample_msb;
    logic             crossing;
    logic             timed_out;
    logic             evaluating;
    logic             commit;
    logic [4:0]       code_eff;
    logic [2:0]       k_eff;

    always_comb begin
        code_legal     = $onehot(amplitude);
        pending_change = code_legal && (amplitude != pending);
        sample_msb     = sample_in[DATA_W-1];
        crossing       = (sample_msb != prev_sign);
        timed_out      = (timeout_cnt == CNT_LAST);
        // Commit decisions use the registered pending code, so a code that
        // arrives on a crossing cycle waits for the next crossing.
        evaluating     = sample_valid_in && (pending != amp_active);
        commit         = evaluating && (crossing || timed_out);
        // The sample that triggers a commit is already scaled by the new code.
        code_eff       = commit ? pending : amp_active;
        k_eff          = code_to_shift(code_eff);

        timeout_cnt_next = timeout_cnt;
        if (commit || pending_change || (pending == amp_active)) begin
            timeout_cnt_next = '0;
        end else if (sample_valid_in) begin
            timeout_cnt_next = timeout_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= CODE_DIV1;
            amp_active  <= CODE_DIV1;
            amp_update  <= 1'b0;
            timeout_cnt <= '0;
            prev_sign   <= 1'b0;
        end else begin
            if (code_legal) begin
                pending <= amplitude;
            end
            if (commit) begin
                amp_active <= pending;
            end
            amp_update  <= commit;
            timeout_cnt <= timeout_cnt_next;
            if (sample_valid_in) begin
                prev_sign <= sample_msb;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: stage 1 converts to two's complement and latches the shift,
    // stage 2 shifts and converts back to offset binary.
    // -----------------------------------------------------------------------
    logic signed [DATA_W-1:0] s1_data;
    logic [2:0]               s1_k;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] scaled;

`ifdef DDS_AMP_ROUND_EN
    logic signed [DATA_W:0] s1_ext;
    logic signed [DATA_W:0] round_bias;
    logic signed [DATA_W:0] rounded;

    // One guard bit keeps the bias add from wrapping; for k>=1 the shifted
    // result always fits back into DATA_W bits. Bias is 0 when k=0.
    always_comb begin
        s1_ext     = {s1_data[DATA_W-1], s1_data};
        round_bias = ({{DATA_W{1'b0}}, 1'b1} << s1_k) >> 1;
        rounded    = s1_ext + round_bias;
        scaled     = DATA_W'(rounded >>> s1_k);
    end
`else
    always_comb begin
        scaled = s1_data >>> s1_k;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data          <= '0;
            s1_k             <= '0;
            s1_valid         <= 1'b0;
            sample_out       <= MIDSCALE;
            sample_valid_out <= 1'b0;
        end else begin
            s1_valid <= sample_valid_in;
            if (sample_valid_in) begin
                s1_data <= {~sample_in[DATA_W-1], sample_in[DATA_W-2:0]};
                s1_k    <= k_eff;
            end
            sample_valid_out <= s1_valid;
            if (s1_valid) begin
                sample_out <= {~scaled[DATA_W-1], scaled[DATA_W-2:0]};
            end
        end
    end

endmodule

// File: tb/tb_dds_amplitude_apply.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for dds_amplitude_apply (DATA_W=8, TIMEOUT_SAMPLES=4).
// Stimulus pushes hand-computed expected samples; a negedge monitor pops them
// whenever sample_valid_out is high and also checks the 2-clock valid delay.
// ---------------------------------------------------------------------------
module tb_dds_amplitude_apply;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] amplitude;
    logic [7:0] sample_in;
    logic       sample_valid_in;
    logic [7:0] sample_out;
    logic       sample_valid_out;
    logic [4:0] amp_active;
    logic       amp_update;

    always #5 clk = ~clk;

    dds_amplitude_apply #(
        .DATA_W          (8),
        .TIMEOUT_SAMPLES (4),
        .CNT_W           (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .amplitude        (amplitude),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .amp_active       (amp_active),
        .amp_update       (amp_update)
    );

`ifdef DDS_AMP_ROUND_EN
    localparam logic [7:0] EXP_FF_DIV4 = 8'hA0;
`else
    localparam logic [7:0] EXP_FF_DIV4 = 8'h9F;
`endif

    typedef struct {
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   upd_pulses = 0;
    int   upd_base   = 0;
    logic vd1 = 1'b0;
    logic vd2 = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // One clock of stimulus; expected output is queued for valid samples.
    task automatic cyc(input logic r, input logic [4:0] amp, input logic [7:0] din,
                       input logic v, input logic [7:0] exp_out, input string name);
        rst             = r;
        amplitude       = amp;
        sample_in       = din;
        sample_valid_in = v;
        if (v && !r) sb_q.push_back('{exp_out, name});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, "bubble");
    endtask

    // Reference valid pipeline: two clocks of delay, cleared by reset.
    always @(posedge clk) begin
        if (rst) begin
            vd1 <= 1'b0;
            vd2 <= 1'b0;
        end else begin
            vd2 <= vd1;
            vd1 <= sample_valid_in;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("valid_out_delay", {31'd0, sample_valid_out}, {31'd0, vd2});
        if (amp_update === 1'b1) upd_pulses++;
        if (sample_valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", sample_out);
            end else begin
                e = sb_q.pop_front();
                check(e.name, {24'd0, sample_out}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with valid toggling
        cyc(1'b1, 5'd0, 8'h12, 1'b1, 8'h00, "rst");
        cyc(1'b1, 5'd0, 8'h34, 1'b0, 8'h00, "rst");
        cyc(1'b1, 5'd0, 8'h56, 1'b1, 8'h00, "rst");
        check("rst_amp_active", {27'd0, amp_active}, 32'd1);
        check("rst_sample_out", {24'd0, sample_out}, 32'h80);
        check("rst_valid_out", {31'd0, sample_valid_out}, 32'd0);
        check("rst_amp_update", {31'd0, amp_update}, 32'd0);
        cyc(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, "idle");
        cyc(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, "idle");
        check("post_rst_valid_out", {31'd0, sample_valid_out}, 32'd0);
        check("post_rst_sample_out", {24'd0, sample_out}, 32'h80);

        // Passthrough with code 1
        cyc(1'b0, 5'd1, 8'h00, 1'b1, 8'h00, "pass_00");
        cyc(1'b0, 5'd1, 8'h80, 1'b1, 8'h80, "pass_80");
        cyc(1'b0, 5'd1, 8'hFF, 1'b1, 8'hFF, "pass_FF");
        drain();

        // Divide by 4: commit on crossing (prev sign 1, sample 00)
        cyc(1'b0, 5'd4, 8'h00, 1'b0, 8'h00, "set4");
        check("div4_not_yet", {27'd0, amp_active}, 32'd1);
        cyc(1'b0, 5'd4, 8'h00, 1'b1, 8'h60, "div4_00_commit");
        check("div4_update", {31'd0, amp_update}, 32'd1);
        check("div4_active", {27'd0, amp_active}, 32'd4);
        cyc(1'b0, 5'd4, 8'hFF, 1'b1, EXP_FF_DIV4, "div4_FF");
        check("div4_update_pulse_end", {31'd0, amp_update}, 32'd0);
        cyc(1'b0, 5'd4, 8'h00, 1'b1, 8'h60, "div4_00");
        cyc(1'b0, 5'd4, 8'h81, 1'b1, 8'h80, "div4_81");
        drain();

        // Crossing commit of code 16
        cyc(1'b1, 5'd0, 8'h00, 1'b0, 8'h00, "rst");
        check("rst2_amp_active", {27'd0, amp_active}, 32'd1);
        cyc(1'b0, 5'd1, 8'hC0, 1'b1, 8'hC0, "x16_pre");
        cyc(1'b0, 5'd16, 8'hC0, 1'b1, 8'hC0, "x16_C0_a");
        cyc(1'b0, 5'd16, 8'hC0, 1'b1, 8'hC0, "x16_C0_b");
        check("x16_no_update_b", {31'd0, amp_update}, 32'd0);
        cyc(1'b0, 5'd16, 8'hC0, 1'b1, 8'hC0, "x16_C0_c");
        check("x16_no_update_c", {31'd0, amp_update}, 32'd0);
        check("x16_active_hold", {27'd0, amp_active}, 32'd1);
        cyc(1'b0, 5'd16, 8'h70, 1'b1, 8'h7F, "x16_70");
        check("x16_update", {31'd0, amp_update}, 32'd1);
        check("x16_active", {27'd0, amp_active}, 32'd16);
        drain();

        // Timeout commit of code 2 on DC input
        cyc(1'b1, 5'd0, 8'h00, 1'b0, 8'h00, "rst");
        cyc(1'b0, 5'd1, 8'hC0, 1'b1, 8'hC0, "to_pre");
        cyc(1'b0, 5'd2, 8'hC0, 1'b0, 8'h00, "to_set2");
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b0, 5'd2, 8'hC0, 1'b1, 8'hC0, "to_wait");
            check("to_no_update", {31'd0, amp_update}, 32'd0);
        end
        check("to_active_hold", {27'd0, amp_active}, 32'd1);
        cyc(1'b0, 5'd2, 8'hC0, 1'b1, 8'hA0, "to_commit");
        check("to_update", {31'd0, amp_update}, 32'd1);
        check("to_active", {27'd0, amp_active}, 32'd2);
        cyc(1'b0, 5'd2, 8'hC0, 1'b1, 8'hA0, "to_after");
        check("to_update_end", {31'd0, amp_update}, 32'd0);

        // Illegal codes leave pending at 2 (== active): crossings commit nothing
        cyc(1'b0, 5'd3, 8'hC0, 1'b0, 8'h00, "ill3");
        cyc(1'b0, 5'd0, 8'hC0, 1'b0, 8'h00, "ill0");
        cyc(1'b0, 5'd0, 8'h40, 1'b1, 8'h60, "ill_x40");
        check("ill0_no_update", {31'd0, amp_update}, 32'd0);
        cyc(1'b0, 5'd3, 8'hC0, 1'b1, 8'hA0, "ill_xC0");
        check("ill3_no_update", {31'd0, amp_update}, 32'd0);
        check("ill_active", {27'd0, amp_active}, 32'd2);

        // Back to code 1, then rapid 2 -> 8 before any crossing
        cyc(1'b0, 5'd1, 8'hC0, 1'b0, 8'h00, "set1");
        cyc(1'b0, 5'd1, 8'h40, 1'b1, 8'h40, "div1_40");
        check("div1_update", {31'd0, amp_update}, 32'd1);
        check("div1_active", {27'd0, amp_active}, 32'd1);
        cyc(1'b0, 5'd2, 8'h40, 1'b0, 8'h00, "rapid2");
        upd_base = upd_pulses;
        cyc(1'b0, 5'd8, 8'h40, 1'b0, 8'h00, "rapid8");
        cyc(1'b0, 5'd0, 8'hC0, 1'b1, 8'h88, "rapid_commit");
        check("rapid_update", {31'd0, amp_update}, 32'd1);
        check("rapid_active", {27'd0, amp_active}, 32'd8);
        cyc(1'b0, 5'd0, 8'hC0, 1'b1, 8'h88, "rapid_after");
        check("rapid_update_end", {31'd0, amp_update}, 32'd0);
        drain();
        check("rapid_pulse_count", upd_pulses - upd_base, 32'd1);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
